zombie_wave_ctrl: RTL and testbench

- Consumes the slowed game-tick pulse (one Clk cycle wide, once per 4 frames) and schedules zombie spawning in waves.
- Drives the zombie spawn handshake toward the zombie object array, tracks live zombies, and sequences waves with an intermission between them.
- Sits directly downstream of the game-tick divider, alongside the player and zombie motion logic.

---
 rtl/zombie_wave_ctrl_if.sv | 20 ++
 rtl/zombie_wave_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_zombie_wave_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/zombie_wave_ctrl_if.sv
// Spawn handshake between the wave controller and the zombie object array.
// The controller (master) raises spawn_req with a stable spawn_point and holds
// both until the array (slave) answers with spawn_ack.
interface zombie_wave_ctrl_if;
    logic       spawn_req;
    logic [1:0] spawn_point;
    logic       spawn_ack;

    modport master (
        output spawn_req,
        output spawn_point,
        input  spawn_ack
    );

    modport slave (
        input  spawn_req,
        input  spawn_point,
        output spawn_ack
    );
endinterface

// File: rtl/zombie_wave_ctrl.sv
// Zombie wave controller.
// Runs off the slowed game-tick pulse: spawns zombies one at a time through
// the spawn handshake, keeps the live-zombie count, and alternates between
// active waves and timed intermissions until the player dies.
// Optional build macro ZOMBIE_DIFFICULTY_RAMP_EN: when defined, the spawn
// interval shrinks by 2 ticks at every new wave, floored at MIN_INTERVAL.
module zombie_wave_ctrl #(
    parameter int MAX_ZOMBIES    = 8,
    parameter int WAVE_SIZE      = 10,
    parameter int SPAWN_INTERVAL = 30,
    parameter int MIN_INTERVAL   = 8,
    parameter int INTERMISSION   = 120
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      game_tick,
    input  logic                      start,
    input  logic                      player_dead,
    input  logic                      zombie_killed,
    zombie_wave_ctrl_if.master        spawn_if,
    output logic [3:0]                live_count,
    output logic [7:0]                wave_num,
    output logic [1:0]                state,
    output logic                      wave_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_INTER  = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    localparam logic [3:0] MAX_L   = 4'(MAX_ZOMBIES);
    localparam logic [7:0] WAVE_L  = 8'(WAVE_SIZE);
    localparam logic [7:0] SPAWN_L = 8'(SPAWN_INTERVAL);
    localparam logic [7:0] MIN_L   = 8'(MIN_INTERVAL);
    localparam logic [7:0] INTER_L = 8'(INTERMISSION);
    localparam logic [7:0] LFSR_SEED = 8'hA5;

`ifdef ZOMBIE_DIFFICULTY_RAMP_EN
    localparam logic [7:0] RAMP_STEP = 8'd2;
`else
    localparam logic [7:0] RAMP_STEP = 8'd0;
`endif

    state_t     cur, nxt;
    logic [7:0] timer;
    logic [7:0] spawned;
    logic [7:0] interval;
    logic [7:0] interval_nxt;
    logic [7:0] lfsr;
    logic [7:0] lfsr_nxt;
    logic       req_q;
    logic [1:0] pt_q;
    logic       wave_clear;

    // Per-cycle control strobes decoded from the current state.
    logic do_init;
    logic do_accept;
    logic do_issue;
    logic do_tick;
    logic do_complete;
    logic do_advance;
    logic do_drop;
    logic do_kill;

    // Wave is finished once every zombie has been spawned and all are dead.
    assign wave_clear = (spawned == WAVE_L) && (live_count == 4'd0);

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left.
    assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // Interval used for the next wave; a zero step keeps it constant.
    assign interval_nxt = (RAMP_STEP == 8'd0) ? interval :
                          ((interval >= MIN_L + RAMP_STEP) ? interval - RAMP_STEP : MIN_L);

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) cur <= S_IDLE;
        else          cur <= nxt;
    end

    // Next-state logic; a dying player beats wave completion and timer expiry.
    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:   if (start) nxt = S_ACTIVE;
            S_ACTIVE: begin
                if (player_dead)     nxt = S_OVER;
                else if (wave_clear) nxt = S_INTER;
            end
            S_INTER: begin
                if (player_dead)                             nxt = S_OVER;
                else if (game_tick && (timer <= 8'd1))       nxt = S_ACTIVE;
            end
            S_OVER:   if (start) nxt = S_ACTIVE;
            default:  nxt = S_IDLE;
        endcase
    end

    // Control strobes: what the datapath does this cycle in the current state.
    always_comb begin
        do_init     = 1'b0;
        do_accept   = 1'b0;
        do_issue    = 1'b0;
        do_tick     = 1'b0;
        do_complete = 1'b0;
        do_advance  = 1'b0;
        case (cur)
            S_IDLE: do_init = start;
            S_ACTIVE: begin
                if (!player_dead) begin
                    if (wave_clear) begin
                        do_complete = 1'b1;
                    end else if (req_q && spawn_if.spawn_ack) begin
                        // Reload wins over a coincident tick.
                        do_accept = 1'b1;
                    end else begin
                        do_issue = !req_q && (timer == 8'd0) &&
                                   (spawned < WAVE_L) && (live_count < MAX_L);
                        do_tick  = game_tick && (timer != 8'd0);
                    end
                end
            end
            S_INTER: begin
                if (!player_dead && game_tick) begin
                    if (timer <= 8'd1) do_advance = 1'b1;
                    else               do_tick    = 1'b1;
                end
            end
            S_OVER: do_init = start;
            default: ;
        endcase
        do_drop = player_dead && ((cur == S_ACTIVE) || (cur == S_INTER));
        do_kill = zombie_killed && (cur != S_IDLE) && (live_count != 4'd0);
    end

    // Spawn timer, wave bookkeeping, handshake registers and LFSR.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            timer     <= 8'd0;
            spawned   <= 8'd0;
            interval  <= SPAWN_L;
            lfsr      <= LFSR_SEED;
            req_q     <= 1'b0;
            pt_q      <= 2'd0;
            wave_num  <= 8'd0;
            wave_done <= 1'b0;
        end else begin
            wave_done <= do_complete;
            if (do_init) begin
                wave_num <= 8'd1;
                timer    <= SPAWN_L;
                interval <= SPAWN_L;
                spawned  <= 8'd0;
                req_q    <= 1'b0;
            end else begin
                // A dying player abandons the pending spawn without counting it.
                if (do_drop) req_q <= 1'b0;
                if (do_accept) begin
                    req_q   <= 1'b0;
                    spawned <= spawned + 8'd1;
                    timer   <= interval;
                    lfsr    <= lfsr_nxt;
                end
                if (do_issue) begin
                    req_q <= 1'b1;
                    pt_q  <= lfsr[1:0];
                end
                if (do_tick)     timer <= timer - 8'd1;
                if (do_complete) timer <= INTER_L;
                if (do_advance) begin
                    if (wave_num != 8'hFF) wave_num <= wave_num + 8'd1;
                    spawned  <= 8'd0;
                    timer    <= interval_nxt;
                    interval <= interval_nxt;
                end
            end
        end
    end

    // Live-zombie count; a simultaneous spawn and kill cancel out.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            live_count <= 4'd0;
        end else if (do_init) begin
            live_count <= 4'd0;
        end else if (do_accept && !do_kill) begin
            live_count <= live_count + 4'd1;
        end else if (do_kill && !do_accept) begin
            live_count <= live_count - 4'd1;
        end
    end

    assign spawn_if.spawn_req   = req_q;
    assign spawn_if.spawn_point = pt_q;
    assign state                = cur;

endmodule

// File: tb/tb_zombie_wave_ctrl.sv
// Self-checking bench for zombie_wave_ctrl: directed scenarios followed by
// randomized play, all compared cycle by cycle against a behavioural model.
module tb_zombie_wave_ctrl;

    localparam int MAXZ  = 8;
    localparam int WAVE  = 10;
    localparam int SPAWN = 30;
    localparam int MINI  = 8;
    localparam int INTER = 120;
`ifdef ZOMBIE_DIFFICULTY_RAMP_EN
    localparam int WAVE2_INTERVAL = 28;
`else
    localparam int WAVE2_INTERVAL = 30;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       game_tick = 1'b0;
    logic       start = 1'b0;
    logic       player_dead = 1'b0;
    logic       zombie_killed = 1'b0;
    logic [3:0] live_count;
    logic [7:0] wave_num;
    logic [1:0] state;
    logic       wave_done;

    zombie_wave_ctrl_if sif();

    zombie_wave_ctrl #(
        .MAX_ZOMBIES(MAXZ), .WAVE_SIZE(WAVE), .SPAWN_INTERVAL(SPAWN),
        .MIN_INTERVAL(MINI), .INTERMISSION(INTER)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .game_tick(game_tick), .start(start),
        .player_dead(player_dead), .zombie_killed(zombie_killed),
        .spawn_if(sif), .live_count(live_count), .wave_num(wave_num),
        .state(state), .wave_done(wave_done)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Behavioural model: game mode 0 idle, 1 active, 2 intermission, 3 over.
    int m_state, m_req, m_pt, m_live, m_wave, m_done;
    int m_timer, m_spawned, m_interval, m_lfsr;

    task automatic model_reset();
        m_state = 0; m_req = 0; m_pt = 0; m_live = 0; m_wave = 0; m_done = 0;
        m_timer = 0; m_spawned = 0; m_interval = SPAWN; m_lfsr = 'hA5;
    endtask

    task automatic model_step(input bit st, input bit pd, input bit tk, input bit kl, input bit ak);
        bit accepted;
        bit kill_counts;
        int fb;
        accepted    = 0;
        kill_counts = kl && (m_state != 0) && (m_live > 0);
        m_done      = 0;
        if (st && (m_state == 0 || m_state == 3)) begin
            m_state = 1; m_wave = 1; m_interval = SPAWN; m_timer = SPAWN;
            m_spawned = 0; m_live = 0; m_req = 0;
            return;
        end
        if (m_state == 1) begin
            if (pd) begin
                m_state = 3; m_req = 0;
            end else if (m_spawned == WAVE && m_live == 0) begin
                m_state = 2; m_done = 1; m_timer = INTER;
            end else if (m_req == 1 && ak) begin
                accepted = 1; m_req = 0; m_spawned++; m_timer = m_interval;
                fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
                m_lfsr = ((m_lfsr << 1) | fb) & 255;
            end else begin
                if (m_req == 0 && m_timer == 0 && m_spawned < WAVE && m_live < MAXZ) begin
                    m_req = 1; m_pt = m_lfsr & 3;
                end
                if (tk && m_timer > 0) m_timer--;
            end
        end else if (m_state == 2) begin
            if (pd) begin
                m_state = 3;
            end else if (tk) begin
                m_timer--;
                if (m_timer <= 0) begin
                    m_state = 1;
                    if (m_wave < 255) m_wave++;
                    m_spawned = 0;
`ifdef ZOMBIE_DIFFICULTY_RAMP_EN
                    m_interval = (m_interval - 2 > MINI) ? m_interval - 2 : MINI;
`endif
                    m_timer = m_interval;
                end
            end
        end
        if (accepted && !kill_counts) m_live++;
        else if (kill_counts && !accepted) m_live--;
    endtask

    task automatic compare_all();
        chk("state", int'(state), m_state);
        chk("spawn_req", int'(sif.spawn_req), m_req);
        chk("spawn_point", int'(sif.spawn_point), m_pt);
        chk("live_count", int'(live_count), m_live);
        chk("wave_num", int'(wave_num), m_wave);
        chk("wave_done", int'(wave_done), m_done);
    endtask

    // One clock: drive at the falling edge, step the model, check at the next falling edge.
    task automatic cyc(input bit st, input bit pd, input bit tk, input bit kl, input bit ak);
        start = st; player_dead = pd; game_tick = tk; zombie_killed = kl; sif.spawn_ack = ak;
        model_step(st, pd, tk, kl, ak);
        @(negedge Clk);
        compare_all();
    endtask

    task automatic spawn_one();
        int n;
        n = 0;
        while (sif.spawn_req !== 1'b1 && n < 200) begin
            cyc(0, 0, 1, 0, 0);
            n++;
        end
        chk("spawn_wait_in_budget", int'(n < 200), 1);
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic finish_wave();
        int  n;
        bit  seen;
        n = 0; seen = 0;
        while (!seen && n < 3000) begin
            cyc(0, 0, 1, (m_live > 0) && (n % 3 == 0), sif.spawn_req);
            seen = wave_done;
            n++;
        end
        chk("wave_done_in_budget", int'(seen), 1);
    endtask

    initial begin
        int n;
        bit st, pd, tk, kl, ak;
        sif.spawn_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        compare_all();
        Reset_n = 1'b1;

        // First spawn of wave 1 after 30 ticks, held until acknowledged.
        cyc(1, 0, 0, 0, 0);
        chk("start_state", int'(state), 1);
        chk("start_wave", int'(wave_num), 1);
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0, 1, 0, 0);
            if (i == 29) chk("tp1_req_not_yet", int'(sif.spawn_req), 0);
            cyc(0, 0, 0, 0, 0);
        end
        chk("tp1_req", int'(sif.spawn_req), 1);
        chk("tp1_point", int'(sif.spawn_point), 1);
        repeat (19) cyc(0, 0, 0, 0, 0);
        chk("tp1_held_req", int'(sif.spawn_req), 1);
        chk("tp1_held_point", int'(sif.spawn_point), 1);
        cyc(0, 0, 0, 0, 1);
        chk("tp1_live_after_ack", int'(live_count), 1);
        chk("tp1_req_after_ack", int'(sif.spawn_req), 0);

        // Simultaneous kill and ack, then kill at zero.
        spawn_one();
        spawn_one();
        chk("live_three", int'(live_count), 3);
        n = 0;
        while (sif.spawn_req !== 1'b1 && n < 200) begin cyc(0, 0, 1, 0, 0); n++; end
        cyc(0, 0, 0, 1, 1);
        chk("kill_ack_same_cycle", int'(live_count), 3);
        repeat (3) cyc(0, 0, 0, 1, 0);
        chk("live_drained", int'(live_count), 0);
        cyc(0, 0, 0, 1, 0);
        chk("kill_at_zero", int'(live_count), 0);

        // Finish wave 1, sit through the intermission, time wave 2's first spawn.
        finish_wave();
        chk("inter_state", int'(state), 2);
        for (int i = 0; i < INTER; i++) begin
            cyc(0, 0, 1, 0, 0);
            if (i == INTER - 2) chk("inter_not_over", int'(state), 2);
        end
        chk("wave2_state", int'(state), 1);
        chk("wave2_num", int'(wave_num), 2);
        n = 0;
        while (sif.spawn_req !== 1'b1 && n < 300) begin
            cyc(0, 0, 1, 0, 0);
            n++;
            cyc(0, 0, 0, 0, 0);
        end
        chk("wave2_first_spawn_ticks", n, WAVE2_INTERVAL);

        // Player dies with a request pending (ack in the same cycle is lost).
        cyc(0, 1, 0, 0, 1);
        chk("dead_state", int'(state), 3);
        chk("dead_req", int'(sif.spawn_req), 0);
        chk("dead_live", int'(live_count), 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("restart_state", int'(state), 1);
        chk("restart_wave", int'(wave_num), 1);
        chk("restart_live", int'(live_count), 0);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            st = ($urandom % 60) == 0;
            pd = ($urandom % 300) == 0;
            tk = ($urandom % 2) == 0;
            kl = ($urandom % 5) == 0;
            ak = sif.spawn_req ? (($urandom % 3) != 0) : (($urandom % 15) == 0);
            cyc(st, pd, tk, kl, ak);
        end

        // Asynchronous reset in the middle of an intermission.
        cyc(1, 0, 0, 0, 0);
        finish_wave();
        repeat (10) cyc(0, 0, 1, 0, 0);
        chk("pre_reset_inter", int'(state), 2);
        start = 0; player_dead = 0; game_tick = 0; zombie_killed = 0; sif.spawn_ack = 0;
        #3 Reset_n = 1'b0;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_req", int'(sif.spawn_req), 0);
        chk("arst_point", int'(sif.spawn_point), 0);
        chk("arst_live", int'(live_count), 0);
        chk("arst_wave", int'(wave_num), 0);
        chk("arst_done", int'(wave_done), 0);
        model_reset();
        @(negedge Clk);
        compare_all();
        Reset_n = 1'b1;
        cyc(1, 0, 0, 0, 0);
        chk("post_reset_start", int'(state), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
